// File: rtl/uart_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_ram_loader
// Purpose  : Receives an 8N1 UART byte stream and writes it, packed
//            little-endian into 32-bit words, into a single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module uart_ram_loader #(
  parameter int CLK_FREQ         = 27_000_000,
  parameter int BAUD_RATE        = 115200,
  parameter int ADDRESS_BITWIDTH = 13
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        uart_rx,
  input  logic                        start,
  input  logic [ADDRESS_BITWIDTH:0]   word_count,
  output logic                        ram_write_enable,
  output logic [ADDRESS_BITWIDTH-1:0] ram_address,
  output logic [31:0]                 ram_data_in,
  output logic                        busy,
  output logic                        done,
  output logic                        frame_error
);

  localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int c_HALF_BIT     = c_CLKS_PER_BIT / 2;
  localparam int c_CNT_W        = $clog2(c_CLKS_PER_BIT);

  localparam logic [c_CNT_W-1:0]          c_FULL_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0]          c_HALF_LAST = c_CNT_W'(c_HALF_BIT - 1);
  localparam logic [ADDRESS_BITWIDTH:0]   c_WORD_ONE  = 1;
  localparam logic [ADDRESS_BITWIDTH-1:0] c_ADDR_ONE  = 1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    LD_IDLE    = 2'd0,
    LD_RECEIVE = 2'd1,
    LD_WRITE   = 2'd2,
    LD_DONE    = 2'd3
  } ld_state_t;

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  logic               r_rx_meta;
  logic               r_rx_sync;
  rx_state_t          r_rx_state;
  rx_state_t          w_rx_next;
  logic [c_CNT_W-1:0] r_clk_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               w_cnt_clr;
  logic               w_bit_sample;
  logic               w_byte_valid;
  logic               w_frame_err;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receiver state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_rx_state <= RX_IDLE;
    else            r_rx_state <= w_rx_next;
  end

  // Receiver next state, bit-timing control and byte/error strobes
  always_comb begin
    w_rx_next    = r_rx_state;
    w_cnt_clr    = 1'b0;
    w_bit_sample = 1'b0;
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!r_rx_sync) w_rx_next = RX_START;
      end
      RX_START: begin
        // Re-check mid start bit; a line already back high was a glitch
        if (r_clk_cnt == c_HALF_LAST) begin
          w_cnt_clr = 1'b1;
          w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_clk_cnt == c_FULL_LAST) begin
          w_cnt_clr    = 1'b1;
          w_bit_sample = 1'b1;
          if (r_bit_cnt == 3'd7) w_rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_clk_cnt == c_FULL_LAST) begin
          w_cnt_clr    = 1'b1;
          w_byte_valid = r_rx_sync;
          w_frame_err  = !r_rx_sync;
          w_rx_next    = RX_IDLE;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // Receiver bit timer, bit counter and LSB-first shift register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_clk_cnt <= w_cnt_clr ? '0 : r_clk_cnt + 1'b1;
      if (r_rx_state == RX_IDLE) r_bit_cnt <= '0;
      if (w_bit_sample) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_shift   <= {r_rx_sync, r_shift[7:1]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Loader
  // --------------------------------------------------------------------------
  ld_state_t                   r_ld_state;
  ld_state_t                   w_ld_next;
  logic [ADDRESS_BITWIDTH:0]   r_count;
  logic [ADDRESS_BITWIDTH:0]   r_words_written;
  logic [ADDRESS_BITWIDTH-1:0] r_addr;
  logic [1:0]                  r_byte_idx;
  logic [31:0]                 r_word;
  logic [31:0]                 r_data_out;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_frame_error;
  logic                        w_last_word;

  assign w_last_word = (r_words_written + c_WORD_ONE) == r_count;

  // Loader state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_ld_state <= LD_IDLE;
    else            r_ld_state <= w_ld_next;
  end

  // Loader next state; a frame error during a load aborts it
  always_comb begin
    w_ld_next = r_ld_state;
    case (r_ld_state)
      LD_IDLE: begin
        if (start) w_ld_next = (word_count == '0) ? LD_DONE : LD_RECEIVE;
      end
      LD_RECEIVE: begin
        if (w_frame_err)                             w_ld_next = LD_IDLE;
        else if (w_byte_valid && r_byte_idx == 2'd3) w_ld_next = LD_WRITE;
      end
      LD_WRITE: begin
        if (w_frame_err)      w_ld_next = LD_IDLE;
        else if (w_last_word) w_ld_next = LD_DONE;
        else                  w_ld_next = LD_RECEIVE;
      end
      LD_DONE:  w_ld_next = LD_IDLE;
      default:  w_ld_next = LD_IDLE;
    endcase
  end

  // Loader datapath: word assembly, address/count bookkeeping, status flags
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_count         <= '0;
      r_words_written <= '0;
      r_addr          <= '0;
      r_byte_idx      <= '0;
      r_word          <= '0;
      r_data_out      <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_frame_error   <= 1'b0;
    end else begin
      case (r_ld_state)
        LD_IDLE: begin
          if (start) begin
            r_count         <= word_count;
            r_words_written <= '0;
            r_addr          <= '0;
            r_byte_idx      <= '0;
            r_frame_error   <= 1'b0;
            // An empty load completes immediately
            r_done          <= (word_count == '0);
            r_busy          <= (word_count != '0);
          end
        end
        LD_RECEIVE: begin
          if (w_frame_err) begin
            r_busy        <= 1'b0;
            r_frame_error <= 1'b1;
          end else if (w_byte_valid) begin
            r_word[{r_byte_idx, 3'b000} +: 8] <= r_shift;
            r_byte_idx <= r_byte_idx + 1'b1;
            // Output data only changes when a complete word is ready
            if (r_byte_idx == 2'd3) r_data_out <= {r_shift, r_word[23:0]};
          end
        end
        LD_WRITE: begin
          if (w_frame_err) begin
            r_busy        <= 1'b0;
            r_frame_error <= 1'b1;
          end else begin
            r_addr          <= r_addr + c_ADDR_ONE;
            r_words_written <= r_words_written + c_WORD_ONE;
            if (w_last_word) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_write_enable = (r_ld_state == LD_WRITE);
  assign ram_address      = r_addr;
  assign ram_data_in      = r_data_out;
  assign busy             = r_busy;
  assign done             = r_done;
  assign frame_error      = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_ram_loader
// Purpose  : Self-checking bench for uart_ram_loader with a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_ram_loader;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int AW        = 2;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          uart_rx   = 1'b1;
  logic          start     = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          ram_write_enable;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data_in;
  logic          busy;
  logic          done;
  logic          frame_error;

  always #5 sys_clk = ~sys_clk;

  uart_ram_loader #(
    .CLK_FREQ        (CLK_FREQ),
    .BAUD_RATE       (BAUD_RATE),
    .ADDRESS_BITWIDTH(AW)
  ) u_dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .uart_rx         (uart_rx),
    .start           (start),
    .word_count      (word_count),
    .ram_write_enable(ram_write_enable),
    .ram_address     (ram_address),
    .ram_data_in     (ram_data_in),
    .busy            (busy),
    .done            (done),
    .frame_error     (frame_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Write monitor: captures every write strobe, its width and done timing
  logic [31:0]   act_data[$];
  logic [AW-1:0] act_addr[$];
  int            cyc = 0;
  int            last_we_cyc = 0;
  int            done_rise_cyc = 0;
  logic          done_rise_busy = 1'b0;
  int            we_run = 0;
  int            max_we_run = 0;
  logic          done_q = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (ram_write_enable) begin
      act_data.push_back(ram_data_in);
      act_addr.push_back(ram_address);
      last_we_cyc <= cyc;
      we_run      <= we_run + 1;
      if (we_run + 1 > max_we_run) max_we_run <= we_run + 1;
    end else begin
      we_run <= 0;
    end
    if (done && !done_q) begin
      done_rise_cyc  <= cyc;
      done_rise_busy <= busy;
    end
    done_q <= done;
  end

  // Reference model: the bytes of the current load, turned into expected writes
  logic [7:0]    sent_q[$];
  logic [31:0]   exp_data[$];
  logic [AW-1:0] exp_addr[$];

  task automatic model_load(input int nwords);
    for (int k = 0; k < nwords; k++) begin
      logic [31:0] w;
      w = 0;
      for (int j = 0; j < 4; j++) w = w | (32'(sent_q[4*k+j]) << (8*j));
      exp_data.push_back(w);
      exp_addr.push_back(AW'(k % (1 << AW)));
    end
    sent_q.delete();
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, " count"}, 64'(act_data.size()), 64'(exp_data.size()));
    n = (act_data.size() < exp_data.size()) ? act_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s addr%0d", tag, i), 64'(act_addr[i]), 64'(exp_addr[i]));
      check($sformatf("%s data%0d", tag, i), 64'(act_data[i]), 64'(exp_data[i]));
    end
    act_data.delete(); act_addr.delete();
    exp_data.delete(); exp_addr.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = good_stop;
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  // Sends a byte that belongs to the current load and records it for the model
  task automatic send_load_byte(input logic [7:0] b);
    sent_q.push_back(b);
    send_byte(b, 1'b1);
  endtask

  task automatic pulse_start(input int c);
    tick(1);
    start      = 1'b1;
    word_count = (AW+1)'(c);
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(!busy && (done || frame_error)) && n < 3000) begin
      tick(1);
      n++;
    end
    if (n >= 3000) check({tag, " timeout"}, 64'(busy), 64'(0));
  endtask

  logic [7:0] t1_bytes [8] = '{8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h78, 8'h56, 8'h34, 8'h12};

  initial begin
    // Reset state
    tick(3);
    check("rst we",    64'(ram_write_enable), 64'(0));
    check("rst addr",  64'(ram_address),      64'(0));
    check("rst data",  64'(ram_data_in),      64'(0));
    check("rst busy",  64'(busy),             64'(0));
    check("rst done",  64'(done),             64'(0));
    check("rst ferr",  64'(frame_error),      64'(0));
    sys_rst_n = 1'b1;
    tick(3);

    // Two-word load with a fixed image
    pulse_start(2);
    check("t1 busy", 64'(busy), 64'(1));
    for (int i = 0; i < 8; i++) send_load_byte(t1_bytes[i]);
    wait_end("t1");
    model_load(2);
    compare_writes("t1");
    check("t1 done",        64'(done),                        64'(1));
    check("t1 ferr",        64'(frame_error),                 64'(0));
    check("t1 done lat",    64'(done_rise_cyc - last_we_cyc), 64'(1));
    check("t1 busy@done",   64'(done_rise_busy),              64'(0));
    check("t1 we width",    64'(max_we_run),                  64'(1));
    check("t1 final addr",  64'(ram_address),                 64'(2));
    check("t1 hold data",   64'(ram_data_in),                 64'(32'h12345678));

    // Frame error mid-load
    pulse_start(1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    tick(30);
    check("t2 ferr", 64'(frame_error), 64'(1));
    check("t2 busy", 64'(busy),        64'(0));
    check("t2 done", 64'(done),        64'(0));
    compare_writes("t2 nowrite");
    pulse_start(1);
    check("t2 ferr clr", 64'(frame_error), 64'(0));
    check("t2 rebusy",   64'(busy),        64'(1));
    for (int i = 0; i < 4; i++) send_load_byte(8'($urandom));
    wait_end("t2b");
    model_load(1);
    compare_writes("t2b");

    // Short glitch while receiving is not a byte
    pulse_start(1);
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(40);
    check("t3 busy", 64'(busy), 64'(1));
    for (int i = 0; i < 4; i++) send_load_byte(8'($urandom));
    wait_end("t3");
    model_load(1);
    compare_writes("t3");

    // Bytes before start are discarded
    for (int i = 0; i < 4; i++) send_byte(8'hAA, 1'b1);
    tick(20);
    pulse_start(1);
    for (int i = 1; i <= 4; i++) send_load_byte(8'(i));
    wait_end("t4");
    model_load(1);
    compare_writes("t4");
    check("t4 word", 64'(ram_data_in), 64'(32'h04030201));

    // Empty load, then a start pulse ignored while busy
    pulse_start(0);
    tick(1);
    check("t5 zero done", 64'(done), 64'(1));
    check("t5 zero busy", 64'(busy), 64'(0));
    compare_writes("t5 zero");
    pulse_start(3);
    for (int i = 0; i < 4; i++) send_load_byte(8'($urandom));
    pulse_start(1);
    for (int i = 0; i < 8; i++) send_load_byte(8'($urandom));
    wait_end("t5");
    model_load(3);
    compare_writes("t5");
    check("t5 done", 64'(done), 64'(1));

    // Full-RAM load wraps the address back to zero
    pulse_start(4);
    for (int i = 0; i < 16; i++) send_load_byte(8'($urandom));
    wait_end("t6");
    model_load(4);
    compare_writes("t6");
    check("t6 wrap addr", 64'(ram_address), 64'(0));

    // Randomized loads with random inter-byte gaps
    for (int r = 0; r < 5; r++) begin
      int n;
      n = $urandom_range(1, 4);
      pulse_start(n);
      for (int i = 0; i < 4*n; i++) begin
        tick($urandom_range(0, 12));
        send_load_byte(8'($urandom));
      end
      wait_end($sformatf("rnd%0d", r));
      model_load(n);
      compare_writes($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d addr", r), 64'(ram_address), 64'(n % (1 << AW)));
      check($sformatf("rnd%0d done", r), 64'(done),        64'(1));
    end

    // Reset mid-byte during a load
    pulse_start(2);
    send_load_byte(8'hEF); send_load_byte(8'hBE);
    send_load_byte(8'hAD); send_load_byte(8'hDE);
    tick(5);
    model_load(1);
    compare_writes("t7 pre");
    uart_rx = 1'b0;
    tick(3*CPB);
    sys_rst_n = 1'b0;
    #1;
    check("t7 rst addr", 64'(ram_address),      64'(0));
    check("t7 rst data", 64'(ram_data_in),      64'(0));
    check("t7 rst busy", 64'(busy),             64'(0));
    check("t7 rst we",   64'(ram_write_enable), 64'(0));
    tick(3);
    sys_rst_n = 1'b1;
    tick(6*CPB);
    uart_rx = 1'b1;
    tick(2*CPB);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    tick(50);
    compare_writes("t7 nowrite");
    check("t7 busy", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
